// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, PSW flag positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_XOR  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_BIT  = 4'd8,
    OP_BIC  = 4'd9,
    OP_BIS  = 4'd10,
    OP_SRA  = 4'd11,
    OP_RRC  = 4'd12,
    OP_DADD = 4'd13
  } alu_op_e;

  localparam int PSW_V = 4;
  localparam int PSW_N = 2;
  localparam int PSW_Z = 1;
  localparam int PSW_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of decimal addition; digits above 9 are handled arithmetically.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw >= 5'd10);
    sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-step arithmetic/logic, bit-serial shifts and digit-serial BCD add.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BYTE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             bw,
  input  logic             upd,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic [15:0]      psw_i,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      psw_o,
  output logic             out_valid
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);

  alu_state_e       state, state_nxt;
  logic [CNT_W-1:0] step_cnt, steps_in, shift_in, shift_q, nib_total, nib_idx;
  logic [3:0]       op_q;
  logic             bw_q, upd_q, cw, cw_nxt;
  logic [WIDTH-1:0] src_q, acc, acc_nxt, val, flag_val;
  logic [15:0]      psw_q, psw_nxt;
  logic             accept, last_step, shift_nz, is_arith, sub_op, cin;
  logic [IDX_W-1:0] msb_idx, nib_base;
  logic [WIDTH-1:0] ow_mask, ow_m1, bit_k, bit_mask, src_b, sum_w;
  logic [WIDTH:0]   sum_wide;
  logic [BYTE_W:0]  sum_byte;
  logic             c_out, v_out;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_co;

  assign accept    = in_valid && in_ready;
  assign last_step = (step_cnt == CNT_W'(1));

  // Cycle count for a new request; a zero shift count still costs one EXEC cycle.
  always_comb begin
    shift_in = bw ? CNT_W'(src % BYTE_W) : CNT_W'(src % WIDTH);
    steps_in = CNT_W'(1);
    if (op == OP_DADD)
      steps_in = bw ? CNT_W'(BYTE_W / 4) : CNT_W'(WIDTH / 4);
    else if ((op == OP_SRA || op == OP_RRC) && shift_in != '0)
      steps_in = shift_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: if (last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Operand-width views shared by every operation.
  always_comb begin
    ow_mask   = bw_q ? WIDTH'({BYTE_W{1'b1}}) : '1;
    ow_m1     = bw_q ? WIDTH'(BYTE_W - 1) : WIDTH'(WIDTH - 1);
    msb_idx   = bw_q ? IDX_W'(BYTE_W - 1) : IDX_W'(WIDTH - 1);
    bit_k     = (src_q > ow_m1) ? ow_m1 : src_q;
    bit_mask  = WIDTH'(1) << bit_k;
    shift_nz  = (shift_q != '0);
    nib_total = bw_q ? CNT_W'(BYTE_W / 4) : CNT_W'(WIDTH / 4);
    nib_idx   = nib_total - step_cnt;
    nib_base  = IDX_W'({nib_idx, 2'b00});
    nib_a     = acc[nib_base +: 4];
    nib_b     = src_q[nib_base +: 4];
  end

  bcd_digit_add u_bcd (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cw),
    .sum  (nib_s),
    .cout (nib_co)
  );

  // Adder shared by ADD/ADDC/SUB/SUBC/CMP; subtracts add the inverted source.
  always_comb begin
    is_arith = op_q inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP};
    sub_op   = op_q inside {OP_SUB, OP_SUBC, OP_CMP};
    src_b    = sub_op ? ~src_q : src_q;
    case (op_q)
      OP_ADDC, OP_SUBC: cin = cw;
      OP_SUB, OP_CMP:   cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum_wide = {1'b0, acc} + {1'b0, src_b} + (WIDTH+1)'(cin);
    sum_byte = {1'b0, acc[BYTE_W-1:0]} + {1'b0, src_b[BYTE_W-1:0]} + (BYTE_W+1)'(cin);
    sum_w    = bw_q ? {acc[WIDTH-1:BYTE_W], sum_byte[BYTE_W-1:0]} : sum_wide[WIDTH-1:0];
    c_out    = bw_q ? sum_byte[BYTE_W] : sum_wide[WIDTH];
    v_out    = (acc[msb_idx] == src_b[msb_idx]) && (sum_w[msb_idx] != acc[msb_idx]);
  end

  always_comb begin
    val    = acc;
    cw_nxt = cw;
    case (op_q)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: val = sum_w;
      OP_XOR: val = acc ^ src_q;
      OP_AND: val = acc & src_q;
      OP_OR:  val = acc | src_q;
      OP_BIT: val = acc & bit_mask;
      OP_BIC: val = acc & ~bit_mask;
      OP_BIS: val = acc | bit_mask;
      OP_SRA: if (shift_nz) begin
        val          = acc >> 1;
        val[msb_idx] = acc[msb_idx];
      end
      OP_RRC: if (shift_nz) begin
        val          = acc >> 1;
        val[msb_idx] = cw;
        cw_nxt       = acc[0];
      end
      OP_DADD: begin
        val[nib_base +: 4] = nib_s;
        cw_nxt             = nib_co;
      end
      default: val = acc;
    endcase
    acc_nxt  = (acc & ~ow_mask) | (val & ow_mask);
    flag_val = (op_q == OP_CMP) ? sum_w : acc_nxt;
  end

  // RRC and DADD own the carry regardless of upd; undefined opcodes leave the PSW alone.
  always_comb begin
    psw_nxt = psw_q;
    if (op_q <= OP_DADD) begin
      if (upd_q && op_q != OP_DADD) begin
        psw_nxt[PSW_N] = flag_val[msb_idx];
        psw_nxt[PSW_Z] = ((flag_val & ow_mask) == '0);
      end
      if (upd_q && is_arith) begin
        psw_nxt[PSW_C] = c_out;
        psw_nxt[PSW_V] = v_out;
      end
      if (op_q == OP_RRC || op_q == OP_DADD)
        psw_nxt[PSW_C] = cw_nxt;
      if (op_q == OP_DADD && upd_q)
        psw_nxt[PSW_Z] = ((acc_nxt & ow_mask) == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      shift_q  <= '0;
      op_q     <= '0;
      bw_q     <= 1'b0;
      upd_q    <= 1'b0;
      src_q    <= '0;
      psw_q    <= '0;
      acc      <= '0;
      cw       <= 1'b0;
      result   <= '0;
      psw_o    <= '0;
    end else if (accept) begin
      step_cnt <= steps_in;
      shift_q  <= shift_in;
      op_q     <= op;
      bw_q     <= bw;
      upd_q    <= upd;
      src_q    <= src;
      psw_q    <= psw_i;
      acc      <= dst;
      cw       <= psw_i[PSW_C];
    end else if (state == ST_EXEC) begin
      acc      <= acc_nxt;
      cw       <= cw_nxt;
      step_cnt <= step_cnt - CNT_W'(1);
      if (last_step) begin
        result <= acc_nxt;
        psw_o  <= psw_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed checks of seq_alu against an integer-arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int B = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bw, upd, out_valid;
  logic [3:0]   op;
  logic [W-1:0] dst, src, result;
  logic [15:0]  psw_i, psw_o;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] p;
    int          lat;
  } exp_t;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .BYTE_W(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .bw        (bw),
    .upd       (upd),
    .dst       (dst),
    .src       (src),
    .psw_i     (psw_i),
    .result    (result),
    .psw_o     (psw_o),
    .out_valid (out_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: latency counts edges from the accepting edge (inclusive) to the first out_valid.
  function automatic exp_t refModel(input int o, input bit bwm, input bit u, input int d,
                                    input int s, input logic [15:0] pin);
    exp_t e;
    int ow, mask, a, sm, r, c, b, cin, sum, fv, k, n, nc, t;
    ow    = bwm ? B : W;
    mask  = (1 << ow) - 1;
    a     = d & mask;
    sm    = s & mask;
    c     = int'(pin[0]);
    r     = a;
    fv    = 0;
    e.p   = pin;
    e.lat = 2;
    if (o > 13) begin
      e.r = 16'(d);
      return e;
    end
    case (o)
      0, 1, 2, 3, 4: begin
        b   = (o >= 2) ? (~s & mask) : sm;
        cin = (o == 0) ? 0 : ((o == 2 || o == 4) ? 1 : c);
        sum = a + b + cin;
        fv  = sum & mask;
        if (o != 4) r = fv;
        if (u) begin
          e.p[0] = ((sum >> ow) & 1) != 0;
          e.p[4] = (((a >> (ow-1)) & 1) == ((b >> (ow-1)) & 1)) &&
                   (((fv >> (ow-1)) & 1) != ((a >> (ow-1)) & 1));
        end
      end
      5: r = a ^ sm;
      6: r = a & sm;
      7: r = a | sm;
      8, 9, 10: begin
        k = (s > ow - 1) ? ow - 1 : s;
        b = 1 << k;
        r = (o == 8) ? (a & b) : ((o == 9) ? (a & ~b & mask) : (a | b));
      end
      11: begin
        n = s % ow;
        for (int i = 0; i < n; i++) r = (r >> 1) | (r & (1 << (ow-1)));
        e.lat = ((n == 0) ? 1 : n) + 1;
      end
      12: begin
        n = s % ow;
        for (int i = 0; i < n; i++) begin
          nc = r & 1;
          r  = (r >> 1) | (c << (ow-1));
          c  = nc;
        end
        e.p[0] = (c != 0);
        e.lat  = ((n == 0) ? 1 : n) + 1;
      end
      default: begin
        r = 0;
        for (int i = 0; i < ow / 4; i++) begin
          t = ((a >> (4*i)) & 15) + ((sm >> (4*i)) & 15) + c;
          if (t >= 10) begin
            t = t - 10;
            c = 1;
          end else begin
            c = 0;
          end
          r = r | ((t & 15) << (4*i));
        end
        e.p[0] = (c != 0);
        if (u) e.p[1] = (r == 0);
        e.lat = ow / 4 + 1;
      end
    endcase
    if (o > 4) fv = r;
    if (o != 13 && u) begin
      e.p[2] = ((fv >> (ow-1)) & 1) != 0;
      e.p[1] = (fv == 0);
    end
    e.r = 16'((d & ~mask & 32'hFFFF) | r);
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input logic [3:0] o, input logic bwv, input logic updv,
                               input logic [15:0] d, input logic [15:0] s, input logic [15:0] p,
                               output logic [15:0] r, output logic [15:0] pp, output int lat);
    int n;
    @(negedge clk);
    op = o; bw = bwv; upd = updv; dst = d; src = s; psw_i = p; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = result;
    pp = psw_o;
  endtask

  task automatic runCase(input string tag, input logic [3:0] o, input logic bwv, input logic updv,
                         input logic [15:0] d, input logic [15:0] s, input logic [15:0] p,
                         input logic [15:0] er, input logic [15:0] ep, input int el);
    logic [15:0] r, pp;
    int lat;
    applyStimulus(tag, o, bwv, updv, d, s, p, r, pp, lat);
    checkOutput({tag, ".result"}, 32'(r), 32'(er));
    checkOutput({tag, ".psw"}, 32'(pp), 32'(ep));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(el));
    @(posedge clk);
    #1;
    checkOutput({tag, ".pulse"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    exp_t        e;
    logic [15:0] rd, rs, rp;
    logic [3:0]  ro;
    logic        rbw, ru;
    int          acc_cnt, exp_acc, per, pulses, n;

    rst = 1'b1; in_valid = 1'b0; op = '0; bw = 1'b0; upd = 1'b0;
    dst = '0; src = '0; psw_i = '0;
    #1;
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.psw", 32'(psw_o), 32'd0);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    #12;
    @(negedge clk);
    rst = 1'b0;

    runCase("add_ovf", OP_ADD, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0014, 2);
    runCase("sub_byte", OP_SUB, 1'b1, 1'b1, 16'hAB10, 16'h0020, 16'h0000, 16'hABF0, 16'h0004, 2);
    runCase("dadd", OP_DADD, 1'b0, 1'b1, 16'h0958, 16'h0047, 16'h0000, 16'h1005, 16'h0000, 5);
    runCase("sra", OP_SRA, 1'b0, 1'b0, 16'h8000, 16'h0003, 16'h0000, 16'hF000, 16'h0000, 4);
    runCase("bit_clamp", OP_BIT, 1'b1, 1'b1, 16'h12FF, 16'd20, 16'hFFE8, 16'h1280, 16'hFFEC, 2);
    runCase("undef_op", 4'd14, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'hA5A5, 16'h1234, 16'hA5A5, 2);
    runCase("xor_noupd", OP_XOR, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h5A1F, 16'hFF00, 16'h5A1F, 2);
    runCase("rrc", OP_RRC, 1'b0, 1'b1, 16'h0003, 16'h0002, 16'h0000, 16'h8000, 16'h0005, 3);

    // Reset in the middle of a DADD must drop everything and never pulse out_valid.
    @(negedge clk);
    op = OP_DADD; bw = 1'b0; upd = 1'b1; dst = 16'h0958; src = 16'h0047; psw_i = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst.result", 32'(result), 32'd0);
    checkOutput("midrst.psw", 32'(psw_o), 32'd0);
    checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("midrst.no_pulse", 32'(pulses), 32'd0);
    runCase("dadd_after_rst", OP_DADD, 1'b0, 1'b1, 16'h0958, 16'h0047, 16'h0001, 16'h1006, 16'h0000, 5);

    // in_valid held high: one accept per visit to IDLE, nothing queued while busy.
    e   = refModel(int'(OP_XOR), 1'b0, 1'b1, 16'h00FF, 16'h0F0F, 16'h0000);
    per = e.lat + 1;
    exp_acc = (12 + per - 1) / per;
    acc_cnt = 0;
    @(negedge clk);
    op = OP_XOR; bw = 1'b0; upd = 1'b1; dst = 16'h00FF; src = 16'h0F0F; psw_i = 16'h0000;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) acc_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("hold.accepts", 32'(acc_cnt), 32'(exp_acc));
    checkOutput("hold.result", 32'(result), 32'(e.r));
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end

    for (int i = 0; i < 150; i++) begin
      ro  = 4'($urandom_range(0, 15));
      rbw = 1'($urandom_range(0, 1));
      ru  = 1'($urandom_range(0, 1));
      rd  = 16'($urandom);
      rs  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      rp  = 16'($urandom);
      e   = refModel(int'(ro), rbw, ru, int'(rd), int'(rs), rp);
      runCase($sformatf("rand%0d_op%0d", i, ro), ro, rbw, ru, rd, rs, rp, e.r, e.p, e.lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
